// File: rtl/fifo_axis_reader_if.sv
// fifo_axis_reader_if: FIFO-side and AXI-Stream-side signals of the reader; master = reader, slave = environment
interface fifo_axis_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_rd_en_o;
  logic [DATA_WIDTH-1:0] m_axis_tdata_o;
  logic                  m_axis_tvalid_o;
  logic                  m_axis_tready_i;
  logic                  m_axis_tlast_o;
  modport master (
    input  fifo_empty_i, fifo_data_i, m_axis_tready_i,
    output fifo_rd_en_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o
  );
  modport slave (
    output fifo_empty_i, fifo_data_i, m_axis_tready_i,
    input  fifo_rd_en_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o
  );
endinterface

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: FWFT FIFO to AXI-Stream with 2-entry skid buffer; FIFO_AXIS_TLAST_EN adds packet tlast generation
module fifo_axis_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int PKT_LEN_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     a_rst_n_i,
  input  logic                     enable_i,
  input  logic [PKT_LEN_WIDTH-1:0] pkt_len_i,
  output logic                     busy_o,
  fifo_axis_reader_if.master       bus
);
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic                  valid, rd, pop;
  assign valid = cnt_q != 2'd0;
  assign rd    = a_rst_n_i && enable_i && !bus.fifo_empty_i && (cnt_q != 2'd2);
  assign pop   = valid && bus.m_axis_tready_i;
  assign bus.fifo_rd_en_o    = rd;
  assign bus.m_axis_tdata_o  = head_q;
  assign bus.m_axis_tvalid_o = valid;
  assign busy_o              = valid;
  // Occupancy and buffer steering: head takes the incoming word unless it must hold, skid refills head on pop
  always_comb begin
    cnt_d  = cnt_q + {1'b0, rd} - {1'b0, pop};
    head_d = (cnt_q == 2'd2) ? (pop ? skid_q : head_q) :
             (cnt_q == 2'd1 && !pop) ? head_q : bus.fifo_data_i;
    skid_d = (cnt_q == 2'd1 && rd && !pop) ? bus.fifo_data_i : skid_q;
  end
  // Occupancy register; the only buffer state that needs reset
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) cnt_q <= 2'd0;
    else            cnt_q <= cnt_d;
  end
  // Data registers are meaningless while empty, so they carry no reset
  always_ff @(posedge clk_i) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end
`ifdef FIFO_AXIS_TLAST_EN
  logic [PKT_LEN_WIDTH-1:0] beat_q, beat_d, len_q, len_d, eff_len, last_idx;
  logic                     last;
  // Packet position tracking; length is taken live on the first beat and latched for the rest
  always_comb begin
    eff_len  = (beat_q == '0) ? pkt_len_i : len_q;
    last_idx = (eff_len == '0) ? '0 : eff_len - PKT_LEN_WIDTH'(1);
    last     = valid && (beat_q == last_idx);
    beat_d   = pop ? (last ? '0 : beat_q + PKT_LEN_WIDTH'(1)) : beat_q;
    len_d    = (pop && beat_q == '0) ? pkt_len_i : len_q;
  end
  // Beat counter and latched packet length
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      beat_q <= '0;
      len_q  <= '0;
    end else begin
      beat_q <= beat_d;
      len_q  <= len_d;
    end
  end
  assign bus.m_axis_tlast_o = last;
`else
  logic unused_pkt_len;
  assign unused_pkt_len     = ^pkt_len_i;
  assign bus.m_axis_tlast_o = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_axis_reader.sv
// tb_fifo_axis_reader: table vectors, directed packet/reset/drain sequences and random traffic against a queue model
module tb_fifo_axis_reader;
  localparam int DW = 16;
  localparam int PW = 4;
`ifdef FIFO_AXIS_TLAST_EN
  localparam bit TL = 1'b1;
`else
  localparam bit TL = 1'b0;
`endif
  typedef struct {
    bit          en, rdy, rd, v;
    logic [DW-1:0] d;
  } vec_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] pkt_len = '0;
  logic          busy;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            beat = 0, cur_len = 0;
  int            n_cmp = 0, n_bad = 0;
  fifo_axis_reader_if #(.DATA_WIDTH(DW)) bus ();
  fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN_WIDTH(PW)) dut (
    .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(en), .pkt_len_i(pkt_len), .busy_o(busy), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic drive_fifo();
    bus.fifo_empty_i = (src_q.size() == 0);
    bus.fifo_data_i  = (src_q.size() != 0) ? src_q[0] : '0;
  endtask
  function automatic int eff_len();
    int l;
    l = (beat == 0) ? int'(pkt_len) : cur_len;
    return (l == 0) ? 1 : l;
  endfunction
  task automatic step(input bit e, input bit r, output bit rd_s, output bit v_s, output logic [DW-1:0] d_s, output bit l_s);
    bit exp_rd, exp_v, is_last;
    en = e;
    bus.m_axis_tready_i = r;
    drive_fifo();
    #1;
    exp_rd  = e && src_q.size() != 0 && exp_q.size() < 2;
    exp_v   = exp_q.size() != 0;
    is_last = exp_v && beat == eff_len() - 1;
    chk("rd_en", bus.fifo_rd_en_o, exp_rd);
    chk("tvalid", bus.m_axis_tvalid_o, exp_v);
    chk("busy", busy, exp_v);
    chk("tlast", bus.m_axis_tlast_o, TL && is_last);
    if (exp_v) chk("tdata", bus.m_axis_tdata_o, exp_q[0]);
    rd_s = bus.fifo_rd_en_o;
    v_s  = bus.m_axis_tvalid_o;
    d_s  = bus.m_axis_tdata_o;
    l_s  = bus.m_axis_tlast_o;
    @(posedge clk);
    #1;
    if (exp_v && r) begin
      if (beat == 0) cur_len = (pkt_len == 0) ? 1 : int'(pkt_len);
      beat = is_last ? 0 : beat + 1;
      void'(exp_q.pop_front());
    end
    if (exp_rd) exp_q.push_back(src_q[0]);
    if (rd_s && src_q.size() != 0) void'(src_q.pop_front());
    drive_fifo();
  endtask
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_tvalid"}, bus.m_axis_tvalid_o, 0);
    chk({tag, "_rst_tlast"}, bus.m_axis_tlast_o, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    chk({tag, "_rst_rd_en"}, bus.fifo_rd_en_o, 0);
    exp_q.delete();
    beat = 0;
    cur_len = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic stream(input int n, output logic [15:0] mask, output int np);
    bit rd_s, v_s, l_s;
    logic [DW-1:0] d_s;
    int tgt;
    repeat (n) src_q.push_back(DW'($urandom));
    tgt = src_q.size() + exp_q.size();
    mask = '0;
    np = 0;
    for (int c = 0; c < 8 * tgt + 10 && np < tgt; c++) begin
      step(1'b1, 1'b1, rd_s, v_s, d_s, l_s);
      if (v_s) begin
        if (l_s) mask[np] = 1'b1;
        np++;
      end
    end
  endtask
  initial begin
    vec_t tab[13];
    bit rd_s, v_s, l_s;
    logic [DW-1:0] d_s;
    logic [15:0] mask;
    int np, nrd;
    tab[0]  = '{1, 1, 1, 0, 'h0};
    tab[1]  = '{1, 1, 1, 1, 'hA1};
    tab[2]  = '{1, 1, 1, 1, 'hA2};
    tab[3]  = '{1, 1, 0, 1, 'hA3};
    tab[4]  = '{1, 1, 0, 0, 'h0};
    tab[5]  = '{1, 0, 1, 0, 'h0};
    tab[6]  = '{1, 0, 1, 1, 'hB1};
    tab[7]  = '{1, 0, 0, 1, 'hB1};
    tab[8]  = '{1, 1, 0, 1, 'hB1};
    tab[9]  = '{1, 1, 1, 1, 'hB2};
    tab[10] = '{1, 1, 1, 1, 'hB3};
    tab[11] = '{1, 1, 0, 1, 'hB4};
    tab[12] = '{1, 1, 0, 0, 'h0};
    src_q = '{'hA1, 'hA2, 'hA3};
    en = 1'b1;
    bus.m_axis_tready_i = 1'b1;
    pkt_len = 1;
    drive_fifo();
    do_reset("init");
    for (int i = 0; i < 13; i++) begin
      if (i == 5) src_q = '{'hB1, 'hB2, 'hB3, 'hB4};
      step(tab[i].en, tab[i].rdy, rd_s, v_s, d_s, l_s);
      chk($sformatf("tab%0d_rd", i), rd_s, tab[i].rd);
      chk($sformatf("tab%0d_v", i), v_s, tab[i].v);
      chk($sformatf("tab%0d_last", i), l_s, TL && tab[i].v);
      if (tab[i].v) chk($sformatf("tab%0d_d", i), d_s, tab[i].d);
    end
    pkt_len = 3;
    stream(7, mask, np);
    chk("len3_beats", np, 7);
    chk("len3_mask", mask, TL ? 16'b0100100 : 16'h0);
    stream(2, mask, np);
    chk("len3_tail_mask", mask, TL ? 16'b10 : 16'h0);
    pkt_len = 0;
    stream(4, mask, np);
    chk("len0_mask", mask, TL ? 16'hF : 16'h0);
    pkt_len = 1;
    stream(4, mask, np);
    chk("len1_mask", mask, TL ? 16'hF : 16'h0);
    repeat (4) src_q.push_back(DW'($urandom));
    step(1'b1, 1'b0, rd_s, v_s, d_s, l_s);
    step(1'b1, 1'b0, rd_s, v_s, d_s, l_s);
    np = 0;
    nrd = 0;
    repeat (2) begin
      step(1'b0, 1'b1, rd_s, v_s, d_s, l_s);
      np += int'(v_s);
      nrd += int'(rd_s);
    end
    chk("drop_pops", np, 2);
    chk("drop_reads", nrd, 0);
    chk("drop_busy", busy, 0);
    pkt_len = 4;
    repeat (4) src_q.push_back(DW'($urandom));
    step(1'b1, 1'b1, rd_s, v_s, d_s, l_s);
    step(1'b1, 1'b1, rd_s, v_s, d_s, l_s);
    step(1'b1, 1'b0, rd_s, v_s, d_s, l_s);
    chk("pre_rst_busy", busy, 1);
    #3;
    do_reset("mid");
    pkt_len = 2;
    stream(1, mask, np);
    chk("post_rst_beats", np, 4);
    chk("post_rst_mask", mask, TL ? 16'b1010 : 16'h0);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(9) < 4 && src_q.size() < 8) src_q.push_back(DW'($urandom));
      if (!(exp_q.size() != 0 && beat == 0) && $urandom_range(4) == 0) pkt_len = PW'($urandom_range(5));
      step($urandom_range(9) < 7, $urandom_range(9) < 6, rd_s, v_s, d_s, l_s);
    end
    for (int c = 0; c < 60 && (src_q.size() != 0 || exp_q.size() != 0); c++)
      step(1'b1, 1'b1, rd_s, v_s, d_s, l_s);
    chk("final_model_empty", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_axis_reader.md
FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of FIFO data and stream tdata; SHALL be >= 1.
REQ-002 Parameter PKT_LEN_WIDTH, default 16: width of packet-length input and beat counter; SHALL be >= 1.
REQ-003 clk_i  in  1  single clock for all logic.
REQ-004 a_rst_n_i  in  1  reset; asynchronous assertion, active-low.
REQ-005 enable_i  in  1  permits new FIFO reads when high.
REQ-006 fifo_empty_i  in  1  empty flag of the upstream first-word-fall-through FIFO.
REQ-007 fifo_data_i  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty_i is low.
REQ-008 fifo_rd_en_o  out  1  FIFO pop strobe.
REQ-009 pkt_len_i  in  PKT_LEN_WIDTH  beats per packet; 0 is treated as 1.
REQ-010 m_axis_tdata_o  out  DATA_WIDTH  stream data.
REQ-011 m_axis_tvalid_o  out  1  stream valid.
REQ-012 m_axis_tready_i  in  1  stream ready.
REQ-013 m_axis_tlast_o  out  1  last beat of packet.
REQ-014 busy_o  out  1  high while the output buffer holds any word.

Function
REQ-015 The block SHALL hold a 2-entry output buffer (head + skid register) with occupancy count 0..2.
REQ-016 fifo_rd_en_o SHALL be combinational: enable_i && !fifo_empty_i && (count < 2).
REQ-017 When fifo_rd_en_o is high, fifo_data_i SHALL be written into the buffer on that clock edge.
REQ-018 Latency: a word popped at edge N SHALL appear on m_axis_tdata_o with m_axis_tvalid_o high after edge N if the buffer was empty.
REQ-019 Pop SHALL occur when m_axis_tvalid_o && m_axis_tready_i; the skid word then moves to the head in the same edge.
REQ-020 Next count SHALL equal count + rd - pop; simultaneous read and pop SHALL leave count unchanged.
REQ-021 Steady state with tready held high and FIFO never empty SHALL sustain one beat per clock.
REQ-022 m_axis_tvalid_o SHALL equal (count != 0); tdata and tvalid SHALL not change while tvalid && !tready.
REQ-023 Words SHALL leave in the exact order read; no word SHALL be dropped or duplicated.
REQ-024 enable_i low SHALL stop new reads only; buffered words SHALL still drain.
REQ-025 busy_o SHALL equal (count != 0).
REQ-026 Beat counter beat_cnt (PKT_LEN_WIDTH bits) SHALL increment on each pop and reset to 0 on the pop carrying tlast.
REQ-027 Packet length SHALL be sampled from pkt_len_i on the first beat (beat_cnt == 0) and held in len_q until that packet's tlast pop.
REQ-028 m_axis_tlast_o SHALL be high when tvalid and beat_cnt == effective_len - 1, effective_len being pkt_len_i at beat_cnt 0, else len_q (0 maps to 1).
REQ-029 pkt_len_i SHALL be required stable while tvalid is high with beat_cnt == 0.

Reset
REQ-030 Asserting a_rst_n_i low SHALL immediately force count = 0, beat_cnt = 0, len_q = 0, m_axis_tvalid_o = 0, m_axis_tlast_o = 0, busy_o = 0, and fifo_rd_en_o = 0, independent of clk_i.
REQ-031 Buffer data registers SHALL not require reset; m_axis_tdata_o is don't-care while tvalid is low.
REQ-032 Reset mid-packet SHALL discard buffered words; the first beat after release starts a new packet.
REQ-033 Reset release SHALL be synchronised externally; the first read SHALL be possible on the first edge after release.

Configuration
REQ-034 Macro FIFO_AXIS_TLAST_EN defined: beat counter, len_q and tlast logic SHALL be compiled in per REQ-026..REQ-029.
REQ-035 Macro FIFO_AXIS_TLAST_EN undefined: m_axis_tlast_o SHALL be tied 0, pkt_len_i ignored, no counter registers; port list unchanged.

Verification
REQ-036 FIFO holds 0xA1,0xA2,0xA3, tready=1, enable=1 -> rd_en high 3 cycles, tdata A1,A2,A3 on consecutive cycles starting 1 cycle after first read.
REQ-037 FIFO holds 4 words, tready=0 -> exactly 2 reads, count=2, tvalid/tdata stable; tready=1 -> remaining words follow in order, no gaps.
REQ-038 pkt_len_i=3, 7 words streamed -> tlast on beats 3 and 6 only, beat_cnt 0 after beat 6.
REQ-039 pkt_len_i=0 -> tlast on every beat; pkt_len_i=1 same.
REQ-040 Reset asserted mid-cycle with count=2 at beat 2 of 4 -> tvalid and tlast low before next edge; after release beat counting restarts at 0.
REQ-041 enable_i dropped with count=2, tready=1 -> no further rd_en, two beats drain, busy_o falls after the second pop.
